// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - opcode in, datapath control flags out, between fetch and decode
interface control_unit_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] Instruction;
    logic           RegWrite;
    logic           MemWrite;
    logic           MemtoReg;
    logic           MemRead;
    logic           Branch;
    logic           ALUSrc;
    logic [3:0]     ALUOp;
    logic           BranchReg;
    logic           PCSave;
    logic           LoadByte;
    logic           LoadHigh;
    logic           Halt;
    logic           Halted;

    // decoder side: consumes the opcode, drives the control flags
    modport master (
        input  Instruction,
        output RegWrite, MemWrite, MemtoReg, MemRead, Branch, ALUSrc, ALUOp,
        output BranchReg, PCSave, LoadByte, LoadHigh, Halt, Halted
    );

    // fetch/datapath side
    modport slave (
        output Instruction,
        input  RegWrite, MemWrite, MemtoReg, MemRead, Branch, ALUSrc, ALUOp,
        input  BranchReg, PCSave, LoadByte, LoadHigh, Halt, Halted
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - single-cycle CPU opcode decoder with sticky halt
module control_unit #(
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    control_unit_if.master bus
);

    typedef enum logic [OPW-1:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    opcode_t op;
    logic    halted_q;
    logic    reg_write_raw;
    logic    mem_write_raw;
    logic    mem_read_raw;
    logic    branch_raw;

    assign op = opcode_t'(bus.Instruction);

    always_comb begin
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        mem_read_raw  = 1'b0;
        branch_raw    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.ALUSrc    = 1'b0;
        bus.ALUOp     = 4'h0;
        bus.BranchReg = 1'b0;
        bus.PCSave    = 1'b0;
        bus.LoadByte  = 1'b0;
        bus.LoadHigh  = 1'b0;
        bus.Halt      = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                reg_write_raw = 1'b1;
                bus.ALUOp     = bus.Instruction;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                reg_write_raw = 1'b1;
                bus.ALUSrc    = 1'b1;
                bus.ALUOp     = bus.Instruction;
            end
            // address = base + offset, so the ALU stays on ADD
            OP_LW: begin
                reg_write_raw = 1'b1;
                mem_read_raw  = 1'b1;
                bus.MemtoReg  = 1'b1;
                bus.ALUSrc    = 1'b1;
            end
            OP_SW: begin
                mem_write_raw = 1'b1;
                bus.ALUSrc    = 1'b1;
            end
            OP_LLB: begin
                reg_write_raw = 1'b1;
                bus.ALUSrc    = 1'b1;
                bus.LoadByte  = 1'b1;
            end
            OP_LHB: begin
                reg_write_raw = 1'b1;
                bus.ALUSrc    = 1'b1;
                bus.LoadByte  = 1'b1;
                bus.LoadHigh  = 1'b1;
            end
            OP_B: begin
                branch_raw = 1'b1;
                bus.ALUSrc = 1'b1;
            end
            OP_BR: begin
                branch_raw    = 1'b1;
                bus.BranchReg = 1'b1;
            end
            OP_PCS: begin
                reg_write_raw = 1'b1;
                bus.PCSave    = 1'b1;
            end
            OP_HLT: begin
                bus.Halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // once halted, nothing with an architectural side-effect may fire
    assign bus.RegWrite = reg_write_raw & ~halted_q;
    assign bus.MemWrite = mem_write_raw & ~halted_q;
    assign bus.MemRead  = mem_read_raw  & ~halted_q;
    assign bus.Branch   = branch_raw    & ~halted_q;
    assign bus.Halted   = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (bus.Halt) begin
            halted_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed checks of opcode decode, halt masking and async reset
module tb_control_unit;

    logic clk;
    logic clk_en;
    logic rst_n;
    int   tests;
    int   failed;

    control_unit_if #(.OPW(4)) bus ();

    control_unit #(.OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 if (clk_en) clk = ~clk;

    // {RegWrite,MemWrite,MemtoReg,MemRead,Branch,ALUSrc,ALUOp[3:0],BranchReg,PCSave,LoadByte,LoadHigh,Halt}
    function automatic logic [14:0] mk(input logic rw, mw, m2r, mrd, br, src,
                                       input logic [3:0] aop,
                                       input logic brr, pcs, lb, lh, h);
        return {rw, mw, m2r, mrd, br, src, aop, brr, pcs, lb, lh, h};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.RegWrite, bus.MemWrite, bus.MemtoReg, bus.MemRead, bus.Branch,
                bus.ALUSrc, bus.ALUOp, bus.BranchReg, bus.PCSave, bus.LoadByte,
                bus.LoadHigh, bus.Halt};
    endfunction

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clock_edge();
        clk_en = 1'b1;
        @(posedge clk);
        #2;
        clk_en = 1'b0;
        #5;
    endtask

    logic [14:0] exp_tab [16];

    initial begin
        clk    = 1'b0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        tests  = 0;
        failed = 0;
        bus.Instruction = 4'h0;

        //                  rw mw m2r mrd br src aluop  brr pcs lb lh h
        exp_tab[0]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        exp_tab[1]  = mk(1, 0, 0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 0);
        exp_tab[2]  = mk(1, 0, 0, 0, 0, 0, 4'h2, 0, 0, 0, 0, 0);
        exp_tab[3]  = mk(1, 0, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0, 0);
        exp_tab[4]  = mk(1, 0, 0, 0, 0, 1, 4'h4, 0, 0, 0, 0, 0);
        exp_tab[5]  = mk(1, 0, 0, 0, 0, 1, 4'h5, 0, 0, 0, 0, 0);
        exp_tab[6]  = mk(1, 0, 0, 0, 0, 1, 4'h6, 0, 0, 0, 0, 0);
        exp_tab[7]  = mk(1, 0, 0, 0, 0, 0, 4'h7, 0, 0, 0, 0, 0);
        exp_tab[8]  = mk(1, 0, 1, 1, 0, 1, 4'h0, 0, 0, 0, 0, 0);
        exp_tab[9]  = mk(0, 1, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0);
        exp_tab[10] = mk(1, 0, 0, 0, 0, 1, 4'h0, 0, 0, 1, 0, 0);
        exp_tab[11] = mk(1, 0, 0, 0, 0, 1, 4'h0, 0, 0, 1, 1, 0);
        exp_tab[12] = mk(0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 0);
        exp_tab[13] = mk(0, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 0, 0);
        exp_tab[14] = mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        exp_tab[15] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);

        #10;
        rst_n = 1'b1;
        #10;
        chk("reset_halted", {14'd0, bus.Halted}, 15'd0);

        for (int op = 0; op < 16; op++) begin
            bus.Instruction = 4'(op);
            #10;
            chk($sformatf("decode_op%0h", op), observed(), exp_tab[op]);
        end
        chk("no_edge_no_halt", {14'd0, bus.Halted}, 15'd0);

        bus.Instruction = 4'hF;
        #10;
        clock_edge();
        chk("halted_set", {14'd0, bus.Halted}, 15'd1);

        bus.Instruction = 4'h0;
        #10;
        chk("halted_add_masked", observed(), mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
        bus.Instruction = 4'h9;
        #10;
        chk("halted_sw_masked", observed(), mk(0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0));
        bus.Instruction = 4'h8;
        #10;
        chk("halted_lw_masked", observed(), mk(0, 0, 1, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0));
        bus.Instruction = 4'hD;
        #10;
        chk("halted_br_masked", observed(), mk(0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0));
        bus.Instruction = 4'h5;
        #10;
        chk("halted_sra_aluop", observed(), mk(0, 0, 0, 0, 0, 1, 4'h5, 0, 0, 0, 0, 0));
        bus.Instruction = 4'hF;
        #10;
        chk("halted_halt_unmasked", observed(), exp_tab[15]);

        bus.Instruction = 4'h0;
        clock_edge();
        chk("halted_sticky", {14'd0, bus.Halted}, 15'd1);

        rst_n = 1'b0;
        #3;
        chk("async_reset_clears", {14'd0, bus.Halted}, 15'd0);
        rst_n = 1'b1;
        #10;
        chk("after_reset_halted", {14'd0, bus.Halted}, 15'd0);
        chk("after_reset_add", observed(), exp_tab[0]);

        bus.Instruction = 4'h3;
        clock_edge();
        chk("no_halt_on_red_edge", {14'd0, bus.Halted}, 15'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
